// File: rtl/fwd_pkg.sv
// Shared types and constants for the operand-forwarding / load-use hazard unit.
package fwd_pkg;

  localparam int unsigned REG_W_DEF    = 5;
  localparam int unsigned ZERO_REG_DEF = 31;
  localparam int unsigned SEL_RF       = 0;

  // History addresses are held at the default width; narrower REG_W values are zero-extended.
  typedef struct packed {
    logic                 valid;
    logic [REG_W_DEF-1:0] addr;
    logic                 is_load;
  } hist_entry_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-side bundle of the forwarding/hazard unit: instruction fields in, mux selects and
// stall status out.
interface fwd_hazard_unit_if
  import fwd_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  logic                       issue_valid;
  logic [NSRC-1:0][REG_W-1:0] src_addr;
  logic [REG_W-1:0]           dst_addr;
  logic                       dst_we;
  logic                       dst_is_load;
  logic                       flush;
  logic [NSRC-1:0][SEL_W-1:0] fwd_sel;
  logic                       stall;
  logic [CNT_W-1:0]           stall_cnt;

  modport master (
    output issue_valid, src_addr, dst_addr, dst_we, dst_is_load, flush,
    input  fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  issue_valid, src_addr, dst_addr, dst_we, dst_is_load, flush,
    output fwd_sel, stall, stall_cnt
  );

endinterface

// File: rtl/fwd_match.sv
// Matches one source register against the producer history and returns the youngest hit
// (0 = register file) plus a flag for a hit in the youngest entry.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int unsigned REG_W    = REG_W_DEF,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ZERO_REG = ZERO_REG_DEF,
  parameter int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
  input  hist_entry_t [DEPTH-1:0] hist_i,
  input  logic [REG_W-1:0]        src_addr_i,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    hit1_o
);

  logic [DEPTH-1:0] hit;
  logic             src_live;
  logic             unused_load;

  assign src_live = (src_addr_i != REG_W'(ZERO_REG));

  always_comb begin
    hit         = '0;
    unused_load = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      hit[k]      = hist_i[k].valid && src_live && (hist_i[k].addr == REG_W_DEF'(src_addr_i));
      unused_load = unused_load ^ hist_i[k].is_load;
    end
  end

  // Scan oldest to youngest so the youngest hit is the last one written.
  always_comb begin
    sel_o = SEL_W'(SEL_RF);
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (hit[k]) begin
        sel_o = SEL_W'(k + 1);
      end
    end
  end

  assign hit1_o = hit[0];

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit. Load-use stall detection and the stall
// counter are built only when FWD_LOAD_STALL_EN is defined.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned REG_W    = REG_W_DEF,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ZERO_REG = ZERO_REG_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  fwd_hazard_unit_if.slave bus_io
);

  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  hist_entry_t [DEPTH-1:0]    hist_q, hist_d;
  logic [NSRC-1:0][SEL_W-1:0] fwd_sel;
  logic [NSRC-1:0]            hit1;
  logic                       stall;
  logic                       dst_live;

  for (genvar s = 0; s < int'(NSRC); s++) begin : g_src
    fwd_match #(
      .REG_W    (REG_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .SEL_W    (SEL_W)
    ) u_match (
      .hist_i     (hist_q),
      .src_addr_i (bus_io.src_addr[s]),
      .sel_o      (fwd_sel[s]),
      .hit1_o     (hit1[s])
    );
  end

  assign bus_io.fwd_sel = fwd_sel;
  assign bus_io.stall   = stall;

  assign dst_live = bus_io.issue_valid && bus_io.dst_we &&
                    (bus_io.dst_addr != REG_W'(ZERO_REG));

  // A stalled or flushed instruction enters as a bubble; flush also kills older entries.
  always_comb begin
    hist_d            = hist_q;
    hist_d[0].valid   = dst_live && !stall && !bus_io.flush;
    hist_d[0].addr    = REG_W_DEF'(bus_io.dst_addr);
`ifdef FWD_LOAD_STALL_EN
    hist_d[0].is_load = bus_io.dst_is_load;
`else
    hist_d[0].is_load = 1'b0;
`endif
    for (int k = 1; k < int'(DEPTH); k++) begin
      hist_d[k] = hist_q[k-1];
      if (bus_io.flush) begin
        hist_d[k].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

`ifdef FWD_LOAD_STALL_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign stall = bus_io.issue_valid && (|hit1) && hist_q[0].is_load;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !bus_io.flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus_io.stall_cnt = cnt_q;
`else
  logic unused_sig;

  // Loads forward like ALU results; the load flag and stage-1 hits go unused.
  assign stall            = 1'b0;
  assign bus_io.stall_cnt = '0;
  assign unused_sig       = ^{hit1, bus_io.dst_is_load};
`endif

endmodule
